raven_adc_ctrl: RTL and testbench

RAVEN_ADC_CTRL -- requirements
Module: raven_adc_ctrl

---
 rtl/raven_adc_pkg.sv | 27 ++
 rtl/raven_adc_ctrl_if.sv | 19 +
 rtl/raven_adc_sar.sv | 94 +++++++++
 rtl/raven_adc_ctrl.sv | 95 +++++++++
 tb/tb_raven_adc_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/raven_adc_pkg.sv
// Shared constants for the Raven SAR ADC controller: FSM encoding, register
// offsets and CTRL/STATUS bit positions.
package raven_adc_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } sar_state_e;

  // Register select, taken from iomem_addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL bits
  localparam int CTRL_EN     = 0;
  localparam int CTRL_START  = 1;
  localparam int CTRL_SEL_LO = 2;

  // STATUS bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

endpackage

// File: rtl/raven_adc_ctrl_if.sv
// Simple iomem bus as seen by the ADC controller (already address-decoded).
interface raven_adc_ctrl_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [3:0]  iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/raven_adc_sar.sv
// Successive-approximation engine: SAMPLE -> one CONVERT cycle per bit -> DONE.
module raven_adc_sar
  import raven_adc_pkg::*;
#(
  parameter int BITS = 10
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,    // next-cycle enable; low aborts a conversion
  input  logic            start,
  input  logic            comp_in,
  output logic [BITS-1:0] dac_code,
  output logic [BITS-1:0] adc_data,
  output logic            adc_hold,
  output logic            busy,
  output logic            done
);

  localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;

  sar_state_e      state_q, state_d;
  logic [BITS-1:0] dac_q, dac_d;
  logic [BITS-1:0] data_q, data_d;
  logic [IW-1:0]   bit_q, bit_d;
  logic            done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      dac_q   <= '0;
      data_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  // Next-state: trial bit is resolved by comp_in, then the next lower bit is tried
  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    data_d  = data_q;
    bit_d   = bit_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start && enable) begin
          state_d = S_SAMPLE;
          done_d  = 1'b0;
        end
      end
      S_SAMPLE: begin
        state_d          = S_CONVERT;
        dac_d            = '0;
        dac_d[BITS-1]    = 1'b1;
        bit_d            = IW'(BITS - 1);
      end
      S_CONVERT: begin
        dac_d[bit_q] = comp_in;
        if (bit_q == '0) begin
          data_d  = dac_d;
          state_d = S_DONE;
        end else begin
          dac_d[bit_q - 1'b1] = 1'b1;
          bit_d               = bit_q - 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Dropping enable mid-conversion discards the conversion entirely
    if (!enable && (state_q == S_SAMPLE || state_q == S_CONVERT)) begin
      state_d = S_IDLE;
      dac_d   = '0;
      data_d  = data_q;
    end
  end

  assign dac_code = dac_q;
  assign adc_data = data_q;
  assign adc_hold = (state_q == S_CONVERT);
  assign busy     = (state_q == S_SAMPLE) || (state_q == S_CONVERT);
  assign done     = done_q;

endmodule

// File: rtl/raven_adc_ctrl.sv
// Raven ADC controller top: iomem register block around the SAR engine.
module raven_adc_ctrl
  import raven_adc_pkg::*;
#(
  parameter int BITS = 10
) (
  input  logic             clk,
  input  logic             resetn,
  raven_adc_ctrl_if.slave  bus,
  input  logic             comp_in,
  output logic [BITS-1:0]  dac_code,
  output logic [1:0]       adc_sel,
  output logic             adc_hold,
  output logic [BITS-1:0]  adc_data,
  output logic             adc_done
);

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, en_d;
  logic [1:0]  sel_q, sel_d;
  logic        accept, is_wr, ctrl_wr, start_req, busy;
  logic [1:0]  reg_sel;

  // A request is taken only when ready is not already pulsing, so valid must be re-sampled
  assign accept    = bus.iomem_valid && !ready_q;
  assign is_wr     = |bus.iomem_wstrb;
  assign reg_sel   = bus.iomem_addr[3:2];
  assign ctrl_wr   = accept && bus.iomem_wstrb[0] && (reg_sel == REG_CTRL);
  assign start_req = ctrl_wr && bus.iomem_wdata[CTRL_START];

  // Bus and CTRL registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
    end
  end

  // CTRL update, ack generation and read mux
  always_comb begin
    en_d    = en_q;
    sel_d   = sel_q;
    ready_d = accept;
    rdata_d = '0;
    if (ctrl_wr) begin
      en_d  = bus.iomem_wdata[CTRL_EN];
      sel_d = bus.iomem_wdata[CTRL_SEL_LO +: 2];
    end
    if (accept && !is_wr) begin
      case (reg_sel)
        REG_CTRL: begin
          rdata_d[CTRL_EN]          = en_q;
          rdata_d[CTRL_SEL_LO +: 2] = sel_q;
        end
        REG_STATUS: begin
          rdata_d[STAT_BUSY] = busy;
          rdata_d[STAT_DONE] = adc_done;
        end
        REG_DATA: rdata_d[BITS-1:0] = adc_data;
        default:  rdata_d = '0;
      endcase
    end
  end

  // The SAR sees the post-write enable so a same-cycle enable+start works
  // and an enable=0 write aborts on the accepting edge.
  raven_adc_sar #(.BITS(BITS)) u_sar (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (en_d),
    .start    (start_req),
    .comp_in  (comp_in),
    .dac_code (dac_code),
    .adc_data (adc_data),
    .adc_hold (adc_hold),
    .busy     (busy),
    .done     (adc_done)
  );

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign adc_sel         = sel_q;

  logic unused_bits;
  assign unused_bits = ^{bus.iomem_wdata[31:4], bus.iomem_addr[1:0]};

endmodule

// File: tb/tb_raven_adc_ctrl.sv
// Self-checking bench for raven_adc_ctrl with an ideal comparator model.
module tb_raven_adc_ctrl;

  localparam int BITS = 10;
  localparam int MAXC = (1 << BITS) - 1;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic            comp_in;
  logic [BITS-1:0] dac_code, adc_data;
  logic [1:0]      adc_sel;
  logic            adc_hold, adc_done;

  int vin_code = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  // Snapshot of side outputs in the cycle the bus ack is seen
  logic [1:0] sel_at_ack;
  logic       done_at_ack, hold_at_ack;

  raven_adc_ctrl_if bus ();

  raven_adc_ctrl #(.BITS(BITS)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .comp_in  (comp_in),
    .dac_code (dac_code),
    .adc_sel  (adc_sel),
    .adc_hold (adc_hold),
    .adc_data (adc_data),
    .adc_done (adc_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal comparator: selected input at or above the DAC level
  assign comp_in = (vin_code >= int'(dac_code));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // One bus transaction; acc is the cycle stamp of the accepting edge
  task automatic xfer(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wdata = wd;
    bus.iomem_wstrb = ws;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.iomem_ready && n < 8);
    chk("rdy_lat", 32'(n), 32'd1);
    rd          = bus.iomem_rdata;
    acc         = cyc;
    sel_at_ack  = adc_sel;
    done_at_ack = adc_done;
    hold_at_ack = adc_hold;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    @(posedge clk); #1;
    chk("rdy_pulse", {31'b0, bus.iomem_ready}, 32'd0);
  endtask

  task automatic rd_reg(input logic [3:0] addr, output logic [31:0] rd);
    int acc;
    xfer(addr, 32'h0, 4'h0, rd, acc);
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] rd;
    int acc;
    xfer(addr, wd, ws, rd, acc);
  endtask

  // Poll for done with a bound; returns cycles from accept edge to done
  task automatic wait_done(input int acc, output int lat);
    int n;
    n = 0;
    while (!adc_done && n < 40) begin
      @(posedge clk); #1; n++;
    end
    lat = cyc - acc;
  endtask

  // Enable + start with the given input and mux select, then check the result
  task automatic convert(input int v, input logic [1:0] s);
    logic [31:0] rd;
    int acc, lat, exp_v;
    vin_code = v;
    exp_v = (v > MAXC) ? MAXC : ((v < 0) ? 0 : v);
    xfer(4'h0, {28'b0, s, 2'b11}, 4'h1, rd, acc);
    chk("done_clr", {31'b0, done_at_ack}, 32'd0);
    wait_done(acc, lat);
    chk("latency", 32'(lat), 32'(BITS + 2));
    chk("adc_data", {22'b0, adc_data}, 32'(exp_v));
    chk("adc_sel", {30'b0, adc_sel}, {30'b0, s});
    rd_reg(4'h8, rd);
    chk("DATA", rd, 32'(exp_v));
    rd_reg(4'h4, rd);
    chk("STATUS", rd, 32'h2);
  endtask

  initial begin
    logic [31:0] rd;
    int acc, acc1, lat;
    logic saw_done;

    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_addr  = 4'h0;
    bus.iomem_wdata = 32'h0;

    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, bus.iomem_ready}, 32'd0);
    chk("rst_rdata", bus.iomem_rdata, 32'd0);
    chk("rst_dac", {22'b0, dac_code}, 32'd0);
    chk("rst_data", {22'b0, adc_data}, 32'd0);
    chk("rst_done", {31'b0, adc_done}, 32'd0);
    chk("rst_hold", {31'b0, adc_hold}, 32'd0);
    chk("rst_sel", {30'b0, adc_sel}, 32'd0);
    @(negedge clk) resetn = 1'b1;

    rd_reg(4'h0, rd); chk("CTRL_rst", rd, 32'h0);
    rd_reg(4'h4, rd); chk("STATUS_rst", rd, 32'h0);
    rd_reg(4'h8, rd); chk("DATA_rst", rd, 32'h0);
    rd_reg(4'hC, rd); chk("RSVD_rst", rd, 32'h0);

    // Directed conversions, including both saturation ends
    convert(335, 2'd0);
    rd_reg(4'h0, rd); chk("CTRL_start_rd0", rd, 32'h1);
    chk("hold_idle", {31'b0, adc_hold}, 32'd0);
    convert(1023, 2'd0);
    convert(0, 2'd0);

    // Reserved offset ignores writes and reads zero
    wr_reg(4'hC, 32'hFFFF_FFFF, 4'hF);
    rd_reg(4'hC, rd); chk("RSVD_wr", rd, 32'h0);

    // Start with enable=0 is ignored; previous done and result stay
    vin_code = 700;
    wr_reg(4'h0, 32'h2, 4'h1);
    repeat (14) @(posedge clk);
    #1;
    rd_reg(4'h4, rd); chk("nostart_STATUS", rd, 32'h2);
    rd_reg(4'h8, rd); chk("nostart_DATA", rd, 32'h0);
    rd_reg(4'h0, rd); chk("nostart_CTRL", rd, 32'h0);

    // Second start while busy does not restart or disturb the first
    vin_code = 600;
    xfer(4'h0, 32'h3, 4'h1, rd, acc1);
    repeat (2) @(posedge clk);
    wr_reg(4'h0, 32'h3, 4'h1);
    wait_done(acc1, lat);
    chk("busy_start_lat", 32'(lat), 32'(BITS + 2));
    rd_reg(4'h8, rd); chk("busy_start_DATA", rd, 32'd600);

    // Byte lane 0 off: CTRL unchanged; wstrb=0 is a read
    wr_reg(4'h0, 32'h0, 4'hE);
    rd_reg(4'h0, rd); chk("wstrb_E", rd, 32'h1);
    xfer(4'h0, 32'h0, 4'h0, rd, acc);
    chk("wstrb_0_rd", rd, 32'h1);
    rd_reg(4'h0, rd); chk("wstrb_0_ctrl", rd, 32'h1);

    // Read-only offsets ignore writes
    wr_reg(4'h8, 32'h3FF, 4'hF);
    rd_reg(4'h8, rd); chk("DATA_ro", rd, 32'd600);
    wr_reg(4'h4, 32'h0, 4'hF);
    rd_reg(4'h4, rd); chk("STATUS_ro", rd, 32'h2);

    // Mux select follows the write right away
    xfer(4'h0, 32'h5, 4'h1, rd, acc);
    chk("sel_next", {30'b0, sel_at_ack}, 32'd1);

    // Abort during CONVERT
    vin_code = 777;
    xfer(4'h0, 32'h7, 4'h1, rd, acc);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_conv", {31'b0, adc_hold}, 32'd1);
    xfer(4'h0, 32'h4, 4'h1, rd, acc);
    chk("abort_hold", {31'b0, hold_at_ack}, 32'd0);
    rd_reg(4'h4, rd); chk("abort_STATUS", rd, 32'h0);
    rd_reg(4'h8, rd); chk("abort_DATA", rd, 32'd600);
    repeat (15) @(posedge clk);
    #1;
    chk("abort_nodone", {31'b0, adc_done}, 32'd0);

    // Reset in the middle of a conversion
    vin_code = 900;
    xfer(4'h0, 32'h3, 4'h1, rd, acc);
    repeat (4) @(posedge clk);
    @(negedge clk) resetn = 1'b0;
    #1;
    chk("mrst_dac", {22'b0, dac_code}, 32'd0);
    chk("mrst_data", {22'b0, adc_data}, 32'd0);
    chk("mrst_hold", {31'b0, adc_hold}, 32'd0);
    chk("mrst_done", {31'b0, adc_done}, 32'd0);
    chk("mrst_sel", {30'b0, adc_sel}, 32'd0);
    chk("mrst_ready", {31'b0, bus.iomem_ready}, 32'd0);
    @(negedge clk) resetn = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (adc_done) saw_done = 1'b1;
    end
    chk("mrst_nodone", {31'b0, saw_done}, 32'd0);
    rd_reg(4'h0, rd); chk("mrst_CTRL", rd, 32'h0);
    convert(512, 2'd0);

    // Randomized conversions against the ideal-SAR model (result == input code)
    for (int i = 0; i < 8; i++) begin
      convert(int'($urandom_range(0, MAXC)), 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
